rom_image_reader: RTL and testbench

// - Reads one vector image from image ROM, from a start address up to its last-point marker.
// - Each ROM point is relative to the image mid point. The block re-bases it onto a screen position.
// - Emits the points as a valid/ready stream of 8-bit X/Y beam coordinates for the vector drawer.
// - Sits between the image ROM and the beam output; the game logic starts one image per request.

---
 rtl/rom_image_reader_if.sv | 25 ++
 rtl/rom_image_reader.sv | 188 ++++++++++++++++++
 tb/tb_rom_image_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_image_reader_if.sv
// Point stream from the image reader to the vector drawer.
// Signals: pt_valid/pt_ready handshake, pt_x/pt_y beam coords, pt_blank pen-up flag.
interface rom_image_reader_if;
  logic       pt_valid;
  logic       pt_ready;
  logic [7:0] pt_x;
  logic [7:0] pt_y;
  logic       pt_blank;

  modport master (
    output pt_valid,
    output pt_x,
    output pt_y,
    output pt_blank,
    input  pt_ready
  );

  modport slave (
    input  pt_valid,
    input  pt_x,
    input  pt_y,
    input  pt_blank,
    output pt_ready
  );
endinterface

// File: rtl/rom_image_reader.sv
// Walks one vector image in ROM and streams its points re-based onto a screen position.
// Ports: clk, rst (async high), start/img_adr/mid_*/pos_* request, rom_adr/rom_data
// ROM bus (1-cycle latency), pt stream (master modport), busy/done/err status.
// Optional: define ROM_READER_CLIP_EN to saturate off-screen points and force them blank.
module rom_image_reader #(
  parameter int ADR_W   = 8,
  parameter int MAX_PTS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] img_adr,
  input  logic [7:0]       mid_x,
  input  logic [7:0]       mid_y,
  input  logic [7:0]       pos_x,
  input  logic [7:0]       pos_y,
  output logic [ADR_W-1:0] rom_adr,
  input  logic [17:0]      rom_data,
  rom_image_reader_if.master pt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(MAX_PTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OUT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADR_W-1:0] adr_q, adr_d;
  logic [7:0] mx_q, mx_d;
  logic [7:0] my_q, my_d;
  logic [7:0] px_q, px_d;
  logic [7:0] py_q, py_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic abort_q, abort_d;
  logic vld_q, vld_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic blank_q, blank_d;
  logic last_q, last_d;

  logic [7:0] x_n;
  logic [7:0] y_n;
  logic       blank_n;
  logic       cnt_max;
  logic       accept;

  assign cnt_max = (cnt_q == CNT_W'(MAX_PTS - 1));
  assign accept  = vld_q && pt.pt_ready;

`ifdef ROM_READER_CLIP_EN
  logic signed [9:0] sx;
  logic signed [9:0] sy;
  logic clip_x;
  logic clip_y;

  always_comb begin
    sx = signed'({2'b00, px_q}) + signed'({2'b00, rom_data[15:8]})
       - signed'({2'b00, mx_q});
    sy = signed'({2'b00, py_q}) + signed'({2'b00, rom_data[7:0]})
       - signed'({2'b00, my_q});
    clip_x = (sx < 10'sd0) || (sx > 10'sd255);
    clip_y = (sy < 10'sd0) || (sy > 10'sd255);
    x_n = (sx < 10'sd0) ? 8'd0 : (sx > 10'sd255) ? 8'hff : sx[7:0];
    y_n = (sy < 10'sd0) ? 8'd0 : (sy > 10'sd255) ? 8'hff : sy[7:0];
    blank_n = rom_data[16] | clip_x | clip_y;
  end
`else
  // Low 8 bits of the 10-bit sum are the modulo-256 screen coordinate.
  always_comb begin
    x_n = px_q + rom_data[15:8] - mx_q;
    y_n = py_q + rom_data[7:0] - my_q;
    blank_n = rom_data[16];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      vld_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      vld_q   <= vld_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = WAIT;
      WAIT: state_d = OUT;
      OUT: begin
        if (accept)
          state_d = (last_q || cnt_max) ? DONE : WAIT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // OUT is entered with vld_q low; its first cycle loads the point,
  // later cycles hold it until the consumer takes it.
  always_comb begin
    adr_d   = adr_q;
    mx_d    = mx_q;
    my_d    = my_q;
    px_d    = px_q;
    py_d    = py_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    vld_d   = vld_q;
    x_d     = x_q;
    y_d     = y_q;
    blank_d = blank_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          adr_d   = img_adr;
          mx_d    = mid_x;
          my_d    = mid_y;
          px_d    = pos_x;
          py_d    = pos_y;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      OUT: begin
        if (!vld_q) begin
          vld_d   = 1'b1;
          x_d     = x_n;
          y_d     = y_n;
          blank_d = blank_n;
          last_d  = rom_data[17];
        end else if (pt.pt_ready) begin
          vld_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          abort_d = !last_q && cnt_max;
          if (!(last_q || cnt_max))
            adr_d = adr_q + ADR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == WAIT) || (state_q == OUT);
    done = (state_q == DONE);
    err  = (state_q == DONE) && abort_q;
  end

  assign rom_adr     = adr_q;
  assign pt.pt_valid = vld_q;
  assign pt.pt_x     = x_q;
  assign pt.pt_y     = y_q;
  assign pt.pt_blank = blank_q;

endmodule

// File: tb/tb_rom_image_reader.sv
// Directed bench for rom_image_reader with a synchronous ROM model.
// Covers reset, cursor image, backpressure, clip, runaway, dropped start, rst, wrap.
module tb_rom_image_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  img_adr = '0;
  logic [7:0]  mid_x = '0;
  logic [7:0]  mid_y = '0;
  logic [7:0]  pos_x = '0;
  logic [7:0]  pos_y = '0;
  logic [7:0]  rom_adr;
  logic [17:0] rom_data = '0;
  logic        busy;
  logic        done;
  logic        err;

  logic [17:0] mem [256];

  rom_image_reader_if pt ();

  rom_image_reader #(
    .ADR_W   (8),
    .MAX_PTS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .img_adr  (img_adr),
    .mid_x    (mid_x),
    .mid_y    (mid_y),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .rom_adr  (rom_adr),
    .rom_data (rom_data),
    .pt       (pt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_adr];

  int n_chk = 0;
  int n_pass = 0;

  int         n_pts;
  logic       got_done;
  logic       got_err;
  logic [7:0] xq [8];
  logic [7:0] yq [8];
  logic       bq [8];
  logic [7:0] aq [8];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_img(input logic [7:0] a, input logic [7:0] mx,
                           input logic [7:0] my, input logic [7:0] px,
                           input logic [7:0] py);
    img_adr = a;
    mid_x = mx;
    mid_y = my;
    pos_x = px;
    pos_y = py;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic collect(input int budget);
    n_pts = 0;
    got_done = 1'b0;
    got_err = 1'b0;
    for (int i = 0; i < budget && !got_done; i++) begin
      if (done) begin
        got_done = 1'b1;
        got_err = err;
        check("busy_at_done", busy, 0);
      end else begin
        if (pt.pt_valid && pt.pt_ready && n_pts < 8) begin
          xq[n_pts] = pt.pt_x;
          yq[n_pts] = pt.pt_y;
          bq[n_pts] = pt.pt_blank;
          aq[n_pts] = rom_adr;
          n_pts++;
        end
        step();
      end
    end
    check("done_seen", got_done, 1);
    if (got_done) begin
      step();
      check("done_pulse_len", done, 0);
    end
  endtask

  logic saw_done;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[48]  = {1'b0, 1'b0, 8'd22, 8'd50};
    mem[49]  = {1'b1, 1'b0, 8'd30, 8'd40};
    mem[16]  = {1'b1, 1'b0, 8'd0, 8'd255};
    mem[100] = {1'b0, 1'b0, 8'd1, 8'd2};
    mem[101] = {1'b0, 1'b0, 8'd2, 8'd3};
    mem[102] = {1'b0, 1'b0, 8'd3, 8'd4};
    mem[103] = {1'b0, 1'b0, 8'd4, 8'd5};
    mem[104] = {1'b0, 1'b0, 8'd5, 8'd6};
    mem[255] = {1'b0, 1'b0, 8'd5, 8'd6};
    mem[0]   = {1'b1, 1'b1, 8'd7, 8'd8};
    pt.pt_ready = 1'b1;

    // reset state
    step();
    step();
    check("rst_valid", pt.pt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_adr", rom_adr, 0);
    check("rst_x", pt.pt_x, 0);
    rst = 1'b0;
    step();

    // cursor image, latency and values
    start_img(8'd48, 8'd22, 8'd50, 8'd100, 8'd100);
    check("cur_busy", busy, 1);
    check("cur_adr0", rom_adr, 48);
    check("cur_lat1", pt.pt_valid, 0);
    step();
    check("cur_lat2", pt.pt_valid, 0);
    step();
    check("cur_lat3", pt.pt_valid, 1);
    collect(30);
    check("cur_n", n_pts, 2);
    check("cur_x0", xq[0], 100);
    check("cur_y0", yq[0], 100);
    check("cur_x1", xq[1], 108);
    check("cur_y1", yq[1], 90);
    check("cur_a0", aq[0], 48);
    check("cur_a1", aq[1], 49);
    check("cur_err", got_err, 0);

    // backpressure on first point
    pt.pt_ready = 1'b0;
    start_img(8'd48, 8'd22, 8'd50, 8'd100, 8'd100);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", pt.pt_valid, 1);
      check("bp_x", pt.pt_x, 100);
      check("bp_y", pt.pt_y, 100);
      check("bp_adr", rom_adr, 48);
      step();
    end
    pt.pt_ready = 1'b1;
    collect(30);
    check("bp_n", n_pts, 2);
    check("bp_x1", xq[1], 108);
    check("bp_y1", yq[1], 90);

    // clip / wrap of off-screen coordinates
    start_img(8'd16, 8'd128, 8'd128, 8'd10, 8'd250);
    collect(30);
    check("clip_n", n_pts, 1);
`ifdef ROM_READER_CLIP_EN
    check("clip_x", xq[0], 0);
    check("clip_y", yq[0], 255);
    check("clip_b", bq[0], 1);
`else
    check("clip_x", xq[0], 138);
    check("clip_y", yq[0], 121);
    check("clip_b", bq[0], 0);
`endif

    // runaway abort after MAX_PTS points
    start_img(8'd100, 8'd0, 8'd0, 8'd0, 8'd0);
    collect(40);
    check("run_n", n_pts, 4);
    check("run_err", got_err, 1);
    check("run_x0", xq[0], 1);
    check("run_x3", xq[3], 4);
    check("run_y3", yq[3], 5);

    // start during busy is dropped
    start_img(8'd48, 8'd22, 8'd50, 8'd100, 8'd100);
    img_adr = 8'd100;
    mid_x = 8'd0;
    mid_y = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    collect(30);
    check("drop_n", n_pts, 2);
    check("drop_x0", xq[0], 100);
    check("drop_x1", xq[1], 108);
    check("drop_y1", yq[1], 90);
    check("drop_err", got_err, 0);

    // async reset mid-image
    pt.pt_ready = 1'b0;
    start_img(8'd48, 8'd22, 8'd50, 8'd100, 8'd100);
    step();
    step();
    check("mid_valid_pre", pt.pt_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", pt.pt_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_adr", rom_adr, 0);
    check("mid_rst_x", pt.pt_x, 0);
    check("mid_rst_done", done, 0);
    step();
    rst = 1'b0;
    pt.pt_ready = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    check("mid_rst_nodone", saw_done, 0);

    // address wrap 255 -> 0
    start_img(8'd255, 8'd0, 8'd0, 8'd0, 8'd0);
    collect(30);
    check("wrap_n", n_pts, 2);
    check("wrap_a0", aq[0], 255);
    check("wrap_a1", aq[1], 0);
    check("wrap_x1", xq[1], 7);
    check("wrap_b1", bq[1], 1);
    check("wrap_err", got_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
